// File: rtl/neuron_core.sv
`timescale 1ns/1ps
// neuron_core
// Wishbone-slave array of 32 integrate-and-fire neurons driven by 256 axons.
//
// Memory map (word aligned, adr[1:0] ignored):
//   0x3000_0000-0x3000_03FC  SYN: 256 x 32-bit rows, row a bit j = axon a -> neuron j
//   0x3000_4000-0x3000_41FC  PAR: neuron j at +16*j: V, T, R, {L,W}
//   0x3000_8000              SPIKE_OUT (read-only)
//   0x3000_8004              TICK (write-only, data ignored)
//   0x3000_C000-0x3000_C3FC  INJ: write to axon a, data ignored
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0], wbs_dat_i[31:0]
//              Wishbone slave inputs
//   wbs_ack_o  registered single-cycle acknowledge
//   wbs_dat_o  registered read data, valid while wbs_ack_o is high
//
// Handshake: an access is taken on the edge where cyc & stb & ~ack; that same
// edge raises ack for exactly one cycle and commits the write / loads read
// data. The master holds address and data stable until it sees ack, so a
// continuously held strobe completes one access every second cycle.
//
// Build option: define NEURON_LEAK_EN to store and apply the per-neuron leak
// L (PAR +0xC bits[15:8]). Without it L is not stored, reads as 0, and the
// tick update uses L = 0.
module neuron_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  logic [31:0]        syn_mem [256];
  logic signed [15:0] v [32];
  logic signed [15:0] t [32];
  logic signed [15:0] r [32];
  logic signed [7:0]  w [32];
`ifdef NEURON_LEAK_EN
  logic signed [7:0]  l [32];
`endif
  logic [31:0]        spike_out;

  logic       access;
  logic       hit_syn, hit_par, hit_spk, hit_tick, hit_inj;
  logic [7:0] word_idx;
  logic [4:0] nrn_idx;
  logic [1:0] par_word;

  assign access   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign hit_syn  = (wbs_adr_i & 32'hFFFF_FC00) == 32'h3000_0000;
  assign hit_par  = (wbs_adr_i & 32'hFFFF_FE00) == 32'h3000_4000;
  assign hit_spk  = (wbs_adr_i & 32'hFFFF_FFFC) == 32'h3000_8000;
  assign hit_tick = (wbs_adr_i & 32'hFFFF_FFFC) == 32'h3000_8004;
  assign hit_inj  = (wbs_adr_i & 32'hFFFF_FC00) == 32'h3000_C000;
  assign word_idx = wbs_adr_i[9:2];
  assign nrn_idx  = wbs_adr_i[8:4];
  assign par_word = wbs_adr_i[3:2];

  // Clamp a 17-bit two's complement sum to 16 bits: overflow shows up as the
  // two top bits disagreeing, and the sign bit tells which rail to pick.
  function automatic logic [15:0] sat16(input logic [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
    else                return s[15:0];
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                          input logic [31:0] dat,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] dat,
                                          input logic [1:0]  sel);
    return {sel[1] ? dat[15:8] : old_v[15:8], sel[0] ? dat[7:0] : old_v[7:0]};
  endfunction

  // Parallel update candidates for INJ (addressed axon row) and TICK.
  logic [15:0] v_inj  [32];
  logic [15:0] v_tick [32];
  logic [15:0] v_leak [32];
  logic [31:0] spk_new;
  logic [31:0] syn_row;
  logic [7:0]  leak_j;

  always_comb begin
    syn_row = syn_mem[word_idx];
    spk_new = '0;
    leak_j  = '0;
    for (int j = 0; j < 32; j++) begin
`ifdef NEURON_LEAK_EN
      leak_j = l[j];
`else
      leak_j = 8'h00;
`endif
      v_inj[j]  = syn_row[j] ? sat16({v[j][15], v[j]} + {{9{w[j][7]}}, w[j]}) : v[j];
      v_leak[j] = sat16({v[j][15], v[j]} + {{9{leak_j[7]}}, leak_j});
      spk_new[j] = $signed(v_leak[j]) >= $signed(t[j]);
      v_tick[j] = spk_new[j] ? r[j] : v_leak[j];
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (hit_syn) begin
      rdata = syn_mem[word_idx];
    end else if (hit_par) begin
      case (par_word)
        2'd0: rdata = {16'h0000, v[nrn_idx]};
        2'd1: rdata = {16'h0000, t[nrn_idx]};
        2'd2: rdata = {16'h0000, r[nrn_idx]};
`ifdef NEURON_LEAK_EN
        default: rdata = {16'h0000, l[nrn_idx], w[nrn_idx]};
`else
        default: rdata = {24'h000000, w[nrn_idx]};
`endif
      endcase
    end else if (hit_spk) begin
      rdata = spike_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      spike_out <= '0;
      for (int i = 0; i < 256; i++) syn_mem[i] <= '0;
      for (int j = 0; j < 32; j++) begin
        v[j] <= '0;
        t[j] <= '0;
        r[j] <= '0;
        w[j] <= '0;
`ifdef NEURON_LEAK_EN
        l[j] <= '0;
`endif
      end
    end else begin
      wbs_ack_o <= access;
      if (access) begin
        wbs_dat_o <= wbs_we_i ? 32'h0 : rdata;
        if (wbs_we_i) begin
          if (hit_syn) syn_mem[word_idx] <= merge32(syn_mem[word_idx], wbs_dat_i, wbs_sel_i);
          if (hit_par) begin
            case (par_word)
              2'd0: v[nrn_idx] <= merge16(v[nrn_idx], wbs_dat_i[15:0], wbs_sel_i[1:0]);
              2'd1: t[nrn_idx] <= merge16(t[nrn_idx], wbs_dat_i[15:0], wbs_sel_i[1:0]);
              2'd2: r[nrn_idx] <= merge16(r[nrn_idx], wbs_dat_i[15:0], wbs_sel_i[1:0]);
              default: begin
                if (wbs_sel_i[0]) w[nrn_idx] <= wbs_dat_i[7:0];
`ifdef NEURON_LEAK_EN
                if (wbs_sel_i[1]) l[nrn_idx] <= wbs_dat_i[15:8];
`endif
              end
            endcase
          end
          if (hit_inj) begin
            for (int j = 0; j < 32; j++) v[j] <= v_inj[j];
          end
          if (hit_tick) begin
            for (int j = 0; j < 32; j++) v[j] <= v_tick[j];
            spike_out <= spk_new;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_core.sv
`timescale 1ns/1ps
module tb_neuron_core;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  neuron_core dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_access(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input string tag,
                           output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o === 1'b1) begin
        got = 1'b1;
        rd  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check({tag, "_ack_seen"}, {31'b0, got}, 32'h1);
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, {31'b0, wbs_ack_o}, 32'h0);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    wb_access(adr, dat, sel, 1'b1, "wr", rd);
  endtask

  task automatic wb_read(input logic [31:0] adr, input string tag);
    logic [31:0] rd;
    logic [31:0] exp;
    wb_access(adr, 32'h0, 4'h0, 1'b0, tag, rd);
    exp = exp_q.pop_front();
    check(tag, rd, exp);
  endtask

  task automatic expect_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    wb_read(adr, tag);
  endtask

  localparam logic [31:0] SYN  = 32'h3000_0000;
  localparam logic [31:0] PAR  = 32'h3000_4000;
  localparam logic [31:0] SPK  = 32'h3000_8000;
  localparam logic [31:0] TICK = 32'h3000_8004;
  localparam logic [31:0] INJ  = 32'h3000_C000;

  function automatic logic [31:0] par_adr(input int j, input int word);
    return PAR + 32'(16 * j) + 32'(4 * word);
  endfunction

`ifdef NEURON_LEAK_EN
  localparam logic [31:0] EXP_V2   = 32'h0000_0003;
  localparam logic [31:0] EXP_LW2  = 32'h0000_FE00;
`else
  localparam logic [31:0] EXP_V2   = 32'h0000_0005;
  localparam logic [31:0] EXP_LW2  = 32'h0000_0000;
`endif

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    expect_read(SYN + 32'h10, 32'h0, "syn_reset");
    expect_read(SPK, 32'h0, "spk_reset");

    // Byte-enable behaviour on SYN
    wb_write(SYN + 32'h10, 32'hA5A5_A5A5, 4'b0011);
    expect_read(SYN + 32'h10, 32'h0000_A5A5, "syn_sel_lo");
    wb_write(SYN + 32'h10, 32'h1234_5678, 4'b1100);
    expect_read(SYN + 32'h10, 32'h1234_A5A5, "syn_sel_hi");

    // Keep idle neurons quiet on ticks: raise every threshold
    for (int j = 0; j < 32; j++) wb_write(par_adr(j, 1), 32'h0000_7FFF, 4'hF);

    // PAR upper bits never stored
    wb_write(par_adr(5, 0), 32'hFFFF_1234, 4'hF);
    expect_read(par_adr(5, 0), 32'h0000_1234, "par_upper0");

    // Neuron 0 integrate and fire
    wb_write(par_adr(0, 1), 32'd10, 4'hF);
    wb_write(par_adr(0, 2), 32'd0, 4'hF);
    wb_write(par_adr(0, 3), 32'h0000_0004, 4'hF);
    wb_write(SYN + 32'hC, 32'h0000_0001, 4'hF);
    repeat (3) wb_write(INJ + 32'hC, 32'hDEAD_BEEF, 4'h0);
    expect_read(par_adr(0, 0), 32'd12, "v0_after_inj3");
    wb_write(TICK, 32'h0, 4'h0);
    expect_read(SPK, 32'h0000_0001, "spk_fire");
    expect_read(par_adr(0, 0), 32'h0, "v0_reset");
    expect_read(TICK, 32'h0, "tick_reads0");
    expect_read(INJ + 32'hC, 32'h0, "inj_reads0");

    // Below threshold: no spike, potential kept
    repeat (2) wb_write(INJ + 32'hC, 32'h0, 4'hF);
    wb_write(TICK, 32'h0, 4'h0);
    expect_read(SPK, 32'h0, "spk_below");
    expect_read(par_adr(0, 0), 32'd8, "v0_hold");
    wb_write(TICK, 32'h0, 4'h0);
    expect_read(SPK, 32'h0, "spk_below2");

    // Saturation on neuron 1 via axon 7
    wb_write(SYN + 32'h1C, 32'h0000_0002, 4'hF);
    wb_write(par_adr(1, 3), 32'h0000_0064, 4'hF);
    wb_write(par_adr(1, 0), 32'd32760, 4'hF);
    wb_write(INJ + 32'h1C, 32'h0, 4'hF);
    expect_read(par_adr(1, 0), 32'h0000_7FFF, "sat_pos");
    expect_read(par_adr(0, 0), 32'd8, "v0_unconnected");
    wb_write(par_adr(1, 3), 32'h0000_0080, 4'hF);
    wb_write(par_adr(1, 0), 32'h0000_8044, 4'hF);
    wb_write(INJ + 32'h1C, 32'h0, 4'hF);
    expect_read(par_adr(1, 0), 32'h0000_8000, "sat_neg");

    // Leak on neuron 2; equality threshold with negative reset on neuron 3
    wb_write(par_adr(2, 0), 32'd5, 4'hF);
    wb_write(par_adr(2, 1), 32'd100, 4'hF);
    wb_write(par_adr(2, 3), 32'h0000_FE00, 4'hF);
    expect_read(par_adr(2, 3), EXP_LW2, "leak_field");
    wb_write(par_adr(3, 0), 32'd50, 4'hF);
    wb_write(par_adr(3, 1), 32'd50, 4'hF);
    wb_write(par_adr(3, 2), 32'h0000_FFF9, 4'hF);
    wb_write(TICK, 32'h0, 4'h0);
    expect_read(SPK, 32'h0000_0008, "spk_equal");
    expect_read(par_adr(3, 0), 32'h0000_FFF9, "v3_reset_neg");
    expect_read(par_adr(2, 0), EXP_V2, "v2_leak");
    expect_read(par_adr(5, 0), 32'h0000_1234, "v5_quiet");

    // Ignored writes
    wb_write(SPK, 32'hFFFF_FFFF, 4'hF);
    expect_read(SPK, 32'h0000_0008, "spk_ro");
    wb_write(32'h3001_0000, 32'hFFFF_FFFF, 4'hF);
    expect_read(32'h3001_0000, 32'h0, "unmapped");

    // Held strobe: ack every second cycle
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = SPK;  wbs_sel_i = 4'hF;
    @(posedge clk); #1;
    check("held_ack1", {31'b0, wbs_ack_o}, 32'h1);
    check("held_dat1", wbs_dat_o, 32'h0000_0008);
    @(posedge clk); #1;
    check("held_ack2", {31'b0, wbs_ack_o}, 32'h0);
    @(posedge clk); #1;
    check("held_ack3", {31'b0, wbs_ack_o}, 32'h1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    check("held_ack4", {31'b0, wbs_ack_o}, 32'h0);

    // Reset in the middle of a write
    wb_write(SYN + 32'h80, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = par_adr(4, 0); wbs_dat_i = 32'h0000_1111; wbs_sel_i = 4'hF;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", {31'b0, wbs_ack_o}, 32'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    expect_read(SYN + 32'h80, 32'h0, "rst_syn80");
    expect_read(SYN + 32'h10, 32'h0, "rst_syn10");
    expect_read(par_adr(4, 0), 32'h0, "rst_v4");
    expect_read(par_adr(0, 1), 32'h0, "rst_t0");
    expect_read(par_adr(3, 0), 32'h0, "rst_v3");
    expect_read(SPK, 32'h0, "rst_spk");
    expect_read(32'h3001_0000, 32'h0, "rst_unmapped");

    check("queue_empty", exp_q.size(), 32'h0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/neuron_core.md
NEURON_CORE -- requirements
Module: neuron_core

Interface
REQ-001 SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports wbs_cyc_i / wbs_stb_i / wbs_we_i, input, 1 each, Wishbone cycle, strobe and write-enable.
REQ-005 SHALL have port wbs_sel_i, input, 4, byte enables; bit n covers byte n.
REQ-006 SHALL have port wbs_adr_i, input, 32, byte address.
REQ-007 SHALL have port wbs_dat_i, input, 32, write data.
REQ-008 SHALL have port wbs_ack_o, output, 1, transfer acknowledge.
REQ-009 SHALL have port wbs_dat_o, output, 32, read data.

Function
REQ-010 SHALL decode four regions, word-aligned (adr[1:0] ignored):
- SYN 0x30000000-0x300003FC: 256 synapse words; word a, bit j = axon a connects to neuron j.
- PAR 0x30004000-0x300041FC: 32 neurons x 4 words at 0x30004000+16*j.
- CTL 0x30008000: SPIKE_OUT, read-only. 0x30008004: TICK, write-only.
- INJ 0x3000C000-0x3000C3FC: spike injection, write-only.
REQ-011 Per-neuron PAR words, all 16-bit signed in bits[15:0], upper bits read 0:
- +0x0 potential V; +0x4 threshold T; +0x8 reset value R.
- +0xC bits[7:0] signed weight W, bits[15:8] signed leak L.
REQ-012 Handshake: wbs_ack_o registered; next edge ack <= cyc & stb & ~ack. Single-cycle pulse, so a continuously held strobe completes every second cycle; the master holds address and data until ack.
REQ-013 Access executes on the edge that raises ack; read data registered onto wbs_dat_o in the same cycle ack is high.
REQ-014 SYN/PAR writes honour wbs_sel_i per byte; CTL/INJ writes ignore wbs_sel_i.
REQ-015 INJ write to axon a = (adr-0x3000C000)/4, data ignored: in one cycle, every neuron j with SYN[a][j]=1 gets V_j <= sat16(V_j + W_j); other neurons unchanged.
REQ-016 TICK write, data ignored, evaluated for all 32 neurons in parallel in one cycle:
- V' = sat16(V + L).
- If V' >= T: spike bit j = 1 and V_j <= R; else spike bit j = 0 and V_j <= V'.
- SPIKE_OUT is replaced wholesale by the new 32-bit vector.
REQ-017 sat16 clamps the result to the range -32768 to 32767; comparisons are signed.
REQ-018 Reads of SYN, PAR and SPIKE_OUT return the stored value. Reads of TICK, INJ or any unmapped address return 0.
REQ-019 Writes to SPIKE_OUT or to unmapped addresses are acknowledged and ignored.
REQ-020 A direct PAR write to V in the same cycle as an INJ/TICK update is impossible (one access per ack); no arbitration required.
REQ-021 wbs_cyc_i or wbs_stb_i low: no state change; ack returns 0 next edge.

Reset
REQ-022 While rst=0, all of the following SHALL be 0: SYN array, PAR array, SPIKE_OUT, wbs_ack_o, wbs_dat_o.
REQ-023 Reset asserted mid-transfer SHALL abort it: no write is committed and ack is 0.

Configuration
REQ-024 Macro NEURON_LEAK_EN defined: leak L applied per REQ-016.
REQ-025 Macro NEURON_LEAK_EN undefined: L is treated as 0, PAR +0xC bits[15:8] are not stored and read 0.

Verification
REQ-026 Write 0xA5A5A5A5 to 0x30000010 with sel=4'b0011, read back -> 0x0000A5A5; ack is high exactly one cycle per access.
REQ-027 Neuron 0: T=10, R=0, W=4, L=0, SYN[3]=0x1; INJ axon 3 three times, then TICK -> SPIKE_OUT=0x00000001, V0 reads 0.
REQ-028 Same setup, INJ twice (V0=8), TICK -> SPIKE_OUT=0, V0=8; a second TICK leaves SPIKE_OUT=0.
REQ-029 V=32760, W=100, INJ -> V reads 32767 (0x7FFF); W=-128 from V=-32700 -> -32768.
REQ-030 NEURON_LEAK_EN defined, V=5, L=-2, T=100, TICK -> V=3; undefined -> V=5.
REQ-031 Write SYN/PAR, assert rst low mid-transfer, release -> all reads 0, SPIKE_OUT=0; read of 0x30010000 -> 0 with ack.
